// File: rtl/commit_tracker_if.sv
// commit_tracker_if: fetch/retire inputs and commit/status outputs of the difftest commit tracker.
// The CPU/harness side uses the master modport; the tracker uses the slave modport.
interface commit_tracker_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);
  logic            fetch_valid_i;
  logic [XLEN-1:0] fetch_pc_i;
  logic [ILEN-1:0] fetch_inst_i;
  logic            fetch_ready_o;
  logic            retire_valid_i;
  logic            retire_wen_i;
  logic [4:0]      retire_rd_i;
  logic [XLEN-1:0] retire_wdata_i;
  logic [7:0]      trap_code_i;
  logic            cmt_valid_o;
  logic [XLEN-1:0] cmt_pc_o;
  logic [ILEN-1:0] cmt_inst_o;
  logic            cmt_wen_o;
  logic [7:0]      cmt_wdest_o;
  logic [XLEN-1:0] cmt_wdata_o;
  logic            skip_o;
  logic            trap_o;
  logic [7:0]      trap_code_o;
  logic [63:0]     cycle_cnt_o;
  logic [63:0]     instr_cnt_o;
  logic [1:0]      err_o;
  logic            timeout_o;

  modport master (
    output fetch_valid_i, fetch_pc_i, fetch_inst_i,
    output retire_valid_i, retire_wen_i, retire_rd_i, retire_wdata_i, trap_code_i,
    input  fetch_ready_o, cmt_valid_o, cmt_pc_o, cmt_inst_o, cmt_wen_o, cmt_wdest_o,
    input  cmt_wdata_o, skip_o, trap_o, trap_code_o, cycle_cnt_o, instr_cnt_o,
    input  err_o, timeout_o
  );

  modport slave (
    input  fetch_valid_i, fetch_pc_i, fetch_inst_i,
    input  retire_valid_i, retire_wen_i, retire_rd_i, retire_wdata_i, trap_code_i,
    output fetch_ready_o, cmt_valid_o, cmt_pc_o, cmt_inst_o, cmt_wen_o, cmt_wdest_o,
    output cmt_wdata_o, skip_o, trap_o, trap_code_o, cycle_cnt_o, instr_cnt_o,
    output err_o, timeout_o
  );
endinterface

// File: rtl/commit_tracker.sv
// commit_tracker: queues fetched {pc,inst} in a DEPTH-entry FIFO and emits one registered
// commit record per retire. Optional macro COMMIT_TIMEOUT_EN enables the idle watchdog (timeout_o).
module commit_tracker #(
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4,
  parameter int TMO   = 4096
) (
  input logic             clock,
  input logic             reset,
  commit_tracker_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  function automatic logic is_trap(input logic [ILEN-1:0] inst);
    return inst[6:0] == 7'h6b;
  endfunction

  function automatic logic is_skip(input logic [ILEN-1:0] inst);
    return inst == ILEN'(32'h0000_007b);
  endfunction

  logic [XLEN-1:0] fifo_pc_r   [DEPTH];
  logic [ILEN-1:0] fifo_inst_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            cmt_valid_r;
  logic [XLEN-1:0] cmt_pc_r;
  logic [ILEN-1:0] cmt_inst_r;
  logic            cmt_wen_r;
  logic [7:0]      cmt_wdest_r;
  logic [XLEN-1:0] cmt_wdata_r;
  logic            skip_r;
  logic            trap_r;
  logic [7:0]      trap_code_r;
  logic [63:0]     cycle_cnt_r;
  logic [63:0]     instr_cnt_r;
  logic [1:0]      err_r;
  logic            full_s;
  logic            empty_s;
  logic            push_s;
  logic            pop_s;
  logic [XLEN-1:0] head_pc_s;
  logic [ILEN-1:0] head_inst_s;

  // Qualifiers use the pre-edge count only: a same-cycle pop never frees room for a push,
  // and a same-cycle push is never bypassed to an empty pop. A committed trap freezes both.
  always_comb begin
    full_s      = (count_r == FULL_CNT);
    empty_s     = (count_r == {CW{1'b0}});
    push_s      = bus.fetch_valid_i & ~full_s & ~trap_r;
    pop_s       = bus.retire_valid_i & ~empty_s & ~trap_r;
    head_pc_s   = fifo_pc_r[rd_ptr_r];
    head_inst_s = fifo_inst_r[rd_ptr_r];
  end

  // FIFO storage; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_pc_r[wr_ptr_r]   <= bus.fetch_pc_i;
      fifo_inst_r[wr_ptr_r] <= bus.fetch_inst_i;
    end
  end

  // Pointers, commit record, trap capture, counters and error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      cmt_valid_r <= 1'b0;
      cmt_pc_r    <= {XLEN{1'b0}};
      cmt_inst_r  <= {ILEN{1'b0}};
      cmt_wen_r   <= 1'b0;
      cmt_wdest_r <= 8'h00;
      cmt_wdata_r <= {XLEN{1'b0}};
      skip_r      <= 1'b0;
      trap_r      <= 1'b0;
      trap_code_r <= 8'h00;
      cycle_cnt_r <= 64'd0;
      instr_cnt_r <= 64'd0;
      err_r       <= 2'b00;
    end else begin
      cmt_valid_r <= 1'b0;
      skip_r      <= 1'b0;
      if (!trap_r) begin
        cycle_cnt_r <= cycle_cnt_r + 64'd1;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r    <= rd_ptr_r + PW'(1);
        cmt_valid_r <= 1'b1;
        cmt_pc_r    <= head_pc_s;
        cmt_inst_r  <= head_inst_s;
        cmt_wen_r   <= bus.retire_wen_i & (bus.retire_rd_i != 5'd0);
        cmt_wdest_r <= {3'b000, bus.retire_rd_i};
        cmt_wdata_r <= bus.retire_wdata_i;
        skip_r      <= is_skip(head_inst_s);
        instr_cnt_r <= instr_cnt_r + 64'd1;
        if (is_trap(head_inst_s)) begin
          trap_r      <= 1'b1;
          trap_code_r <= bus.trap_code_i;
        end
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (bus.fetch_valid_i & full_s & ~trap_r) begin
        err_r[0] <= 1'b1;
      end
      if (bus.retire_valid_i & empty_s & ~trap_r) begin
        err_r[1] <= 1'b1;
      end
    end
  end

  assign bus.fetch_ready_o = ~full_s;
  assign bus.cmt_valid_o   = cmt_valid_r;
  assign bus.cmt_pc_o      = cmt_pc_r;
  assign bus.cmt_inst_o    = cmt_inst_r;
  assign bus.cmt_wen_o     = cmt_wen_r;
  assign bus.cmt_wdest_o   = cmt_wdest_r;
  assign bus.cmt_wdata_o   = cmt_wdata_r;
  assign bus.skip_o        = skip_r;
  assign bus.trap_o        = trap_r;
  assign bus.trap_code_o   = trap_code_r;
  assign bus.cycle_cnt_o   = cycle_cnt_r;
  assign bus.instr_cnt_o   = instr_cnt_r;
  assign bus.err_o         = err_r;

`ifdef COMMIT_TIMEOUT_EN
  logic [31:0] idle_cnt_r;
  logic        timeout_r;

  // Watchdog: cycles since the last commit; flags a hang when work is queued but nothing retires.
  always_ff @(posedge clock) begin
    if (reset) begin
      idle_cnt_r <= 32'd0;
      timeout_r  <= 1'b0;
    end else begin
      if (pop_s) begin
        idle_cnt_r <= 32'd0;
      end else begin
        idle_cnt_r <= idle_cnt_r + 32'd1;
      end
      if ((idle_cnt_r == 32'(TMO)) && !empty_s && !trap_r) begin
        timeout_r <= 1'b1;
`ifndef SYNTHESIS
        if (!timeout_r) begin
          $display("commit timeout pc=%h", head_pc_s);
        end
`endif
      end
    end
  end

  assign bus.timeout_o = timeout_r;
`else
  assign bus.timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_commit_tracker.sv
// tb_commit_tracker: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_commit_tracker;
  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clock = ~clock;

  commit_tracker_if #(.XLEN(XLEN), .ILEN(ILEN)) ifc ();

  commit_tracker #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .TMO(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.slave)
  );

  // Reference model state
  ent_t        m_q[$];
  logic        m_valid, m_skip, m_wen, m_trap, m_timeout;
  logic [63:0] m_pc, m_wdata, m_cycle, m_instr;
  logic [31:0] m_inst;
  logic [7:0]  m_wdest, m_code;
  logic [1:0]  m_err;
  longint      m_idle;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic model_update();
    int   sz;
    ent_t e;
    logic commit;
    m_valid = 1'b0;
    m_skip  = 1'b0;
    if (reset) begin
      m_q.delete();
      {m_wen, m_trap, m_timeout} = '0;
      {m_pc, m_wdata, m_cycle, m_instr} = '0;
      m_inst = '0; m_wdest = '0; m_code = '0; m_err = '0; m_idle = 0;
      return;
    end
    sz = m_q.size();
    commit = !m_trap && ifc.retire_valid_i && (sz > 0);
`ifdef COMMIT_TIMEOUT_EN
    if (m_idle == TMO && sz > 0 && !m_trap) m_timeout = 1'b1;
`endif
    m_idle = commit ? 0 : m_idle + 1;
    if (m_trap) return;
    m_cycle++;
    if (ifc.retire_valid_i) begin
      if (sz == 0) m_err[1] = 1'b1;
      else begin
        e       = m_q.pop_front();
        m_valid = 1'b1;
        m_pc    = e.pc;
        m_inst  = e.inst;
        m_wen   = ifc.retire_wen_i && (ifc.retire_rd_i != 5'd0);
        m_wdest = {3'b000, ifc.retire_rd_i};
        m_wdata = ifc.retire_wdata_i;
        m_skip  = (e.inst == 32'h0000_007b);
        m_instr++;
        if (e.inst[6:0] == 7'h6b) begin
          m_trap = 1'b1;
          m_code = ifc.trap_code_i;
        end
      end
    end
    if (ifc.fetch_valid_i) begin
      if (sz < DEPTH) m_q.push_back('{pc: ifc.fetch_pc_i, inst: ifc.fetch_inst_i});
      else m_err[0] = 1'b1;
    end
  endtask

  task automatic compare_all(input string t);
    check_val({t, ".valid"}, ifc.cmt_valid_o, m_valid);
    check_val({t, ".pc"}, ifc.cmt_pc_o, m_pc);
    check_val({t, ".inst"}, ifc.cmt_inst_o, m_inst);
    check_val({t, ".wen"}, ifc.cmt_wen_o, m_wen);
    check_val({t, ".wdest"}, ifc.cmt_wdest_o, m_wdest);
    check_val({t, ".wdata"}, ifc.cmt_wdata_o, m_wdata);
    check_val({t, ".skip"}, ifc.skip_o, m_skip);
    check_val({t, ".trap"}, ifc.trap_o, m_trap);
    check_val({t, ".code"}, ifc.trap_code_o, m_code);
    check_val({t, ".cycle"}, ifc.cycle_cnt_o, m_cycle);
    check_val({t, ".instr"}, ifc.instr_cnt_o, m_instr);
    check_val({t, ".err"}, ifc.err_o, m_err);
    check_val({t, ".ready"}, ifc.fetch_ready_o, (m_q.size() < DEPTH));
    check_val({t, ".timeout"}, ifc.timeout_o, m_timeout);
  endtask

  task automatic step(input string t);
    @(posedge clock);
    model_update();
    #1;
    compare_all(t);
  endtask

  task automatic drive(input logic fv, input logic [63:0] pc, input logic [31:0] inst,
                       input logic rv, input logic wen, input logic [4:0] rd,
                       input logic [63:0] wdata, input logic [7:0] code);
    ifc.fetch_valid_i  = fv;
    ifc.fetch_pc_i     = pc;
    ifc.fetch_inst_i   = inst;
    ifc.retire_valid_i = rv;
    ifc.retire_wen_i   = wen;
    ifc.retire_rd_i    = rd;
    ifc.retire_wdata_i = wdata;
    ifc.trap_code_i    = code;
  endtask

  task automatic idle_in();
    drive(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 5'd0, 64'd0, 8'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] sav_cyc, sav_ins;
    logic [31:0] r32;
    logic [63:0] r64;
    int          trapped_for;
    idle_in();
    reset = 1'b1;
    step("rst");
    step("rst");
    check_val("rst_ready", ifc.fetch_ready_o, 1'b1);
    check_val("rst_valid", ifc.cmt_valid_o, 1'b0);
    reset = 1'b0;

    // In-order commit of two instructions
    drive(1'b1, 64'h8000_0000, 32'h0010_0093, 1'b0, 1'b0, 5'd0, 64'd0, 8'd0); step("t1");
    drive(1'b1, 64'h8000_0004, 32'h0020_0113, 1'b0, 1'b0, 5'd0, 64'd0, 8'd0); step("t1");
    drive(1'b0, 64'd0, 32'd0, 1'b1, 1'b1, 5'd1, 64'h1111, 8'd0); step("t1");
    check_val("t1_valid0", ifc.cmt_valid_o, 1'b1);
    check_val("t1_pc0", ifc.cmt_pc_o, 64'h8000_0000);
    check_val("t1_wdest0", ifc.cmt_wdest_o, 8'h01);
    drive(1'b0, 64'd0, 32'd0, 1'b1, 1'b1, 5'd2, 64'h2222, 8'd0); step("t1");
    check_val("t1_pc1", ifc.cmt_pc_o, 64'h8000_0004);
    check_val("t1_wdest1", ifc.cmt_wdest_o, 8'h02);
    check_val("t1_instr", ifc.instr_cnt_o, 64'd2);
    idle_in(); step("t1");
    check_val("t1_pulse", ifc.cmt_valid_o, 1'b0);

    // Fill, overflow, drain with pointer wrap
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 64'h1000 + 64'(4 * i), 32'h0000_0013, 1'b0, 1'b0, 5'd0, 64'd0, 8'd0);
      step("t2");
    end
    check_val("t2_ready_full", ifc.fetch_ready_o, 1'b0);
    drive(1'b1, 64'hdead, 32'h0000_0013, 1'b0, 1'b0, 5'd0, 64'd0, 8'd0); step("t2");
    check_val("t2_err_ovf", ifc.err_o, 2'b01);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 5'd3, 64'(i), 8'd0);
      step("t2");
    end
    check_val("t2_last_pc", ifc.cmt_pc_o, 64'h100c);
    check_val("t2_ready_empty", ifc.fetch_ready_o, 1'b1);

    // Retire while empty
    drive(1'b0, 64'd0, 32'd0, 1'b1, 1'b1, 5'd4, 64'd0, 8'd0); step("t3");
    check_val("t3_err_unf", ifc.err_o[1], 1'b1);
    check_val("t3_valid", ifc.cmt_valid_o, 1'b0);
    check_val("t3_instr", ifc.instr_cnt_o, 64'd6);

    // Skip pulse
    drive(1'b1, 64'h2000, 32'h0000_007b, 1'b0, 1'b0, 5'd0, 64'd0, 8'd0); step("t5");
    drive(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 5'd0, 64'd0, 8'd0); step("t5");
    check_val("t5_skip", ifc.skip_o, 1'b1);
    check_val("t5_valid", ifc.cmt_valid_o, 1'b1);
    idle_in(); step("t5");
    check_val("t5_skip_off", ifc.skip_o, 1'b0);

    // Watchdog with one entry queued
    drive(1'b1, 64'h3000, 32'h0000_0013, 1'b0, 1'b0, 5'd0, 64'd0, 8'd0); step("t6");
    idle_in();
    for (int i = 0; i < 20; i++) step("t6");
`ifdef COMMIT_TIMEOUT_EN
    check_val("t6_timeout", ifc.timeout_o, 1'b1);
`else
    check_val("t6_timeout", ifc.timeout_o, 1'b0);
`endif
    drive(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 5'd0, 64'd0, 8'd0); step("t6");

    // Trap and freeze
    drive(1'b1, 64'h4000, 32'h0000_006b, 1'b0, 1'b0, 5'd0, 64'd0, 8'd0); step("t4");
    drive(1'b1, 64'h4004, 32'h0000_0013, 1'b1, 1'b1, 5'd10, 64'd0, 8'h00); step("t4");
    check_val("t4_trap", ifc.trap_o, 1'b1);
    check_val("t4_code", ifc.trap_code_o, 8'h00);
    check_val("t4_valid", ifc.cmt_valid_o, 1'b1);
    sav_cyc = ifc.cycle_cnt_o;
    sav_ins = ifc.instr_cnt_o;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 64'h5000, 32'h0000_0013, 1'b1, 1'b1, 5'd5, 64'd9, 8'h55);
      step("t4");
      check_val("t4_frz_valid", ifc.cmt_valid_o, 1'b0);
    end
    check_val("t4_frz_cycle", ifc.cycle_cnt_o, sav_cyc);
    check_val("t4_frz_instr", ifc.instr_cnt_o, sav_ins);

    // Randomized traffic with occasional traps and resets
    trapped_for = 0;
    for (int i = 0; i < 3000; i++) begin
      reset = (m_trap && trapped_for > 6) || ($urandom_range(0, 199) == 0);
      r32 = $urandom();
      case ($urandom_range(0, 99))
        0:       r32[6:0] = 7'h6b;
        1, 2, 3: r32 = 32'h0000_007b;
        4, 5:    r32[6:0] = 7'h7b;
        default: r32[6:0] = 7'h13;
      endcase
      r64 = {$urandom(), $urandom()};
      drive(($urandom_range(0, 99) < 55), r64, r32, ($urandom_range(0, 99) < 45),
            1'($urandom()), 5'($urandom()), {$urandom(), $urandom()}, 8'($urandom()));
      step("rnd");
      trapped_for = m_trap ? trapped_for + 1 : 0;
    end
    reset = 1'b0;
    idle_in();
    step("end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
